// File: rtl/mem_arb_pkg.sv
// Shared types for the two-client memory arbiter: sequencer states,
// client identifiers and the memory operation encoding.
package mem_arb_pkg;

    // Sequencer states; one transaction walks IDLE -> ISSUE -> WAIT.. -> DONE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Client identifier; a single bit is enough for two clients.
    typedef logic client_t;

    localparam client_t CL_I = 1'b0;   // instruction cache
    localparam client_t CL_D = 1'b1;   // data cache

    // Memory operation latched for the granted client.
    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/rr_select2.sv
// Two-way round-robin picker. A lone requester always wins; on a tie the
// client that was not granted last wins. Purely combinational.
module rr_select2
    import mem_arb_pkg::*;
(
    input  logic    i_req,
    input  logic    d_req,
    input  client_t last_grant,
    output client_t grant,
    output logic    any
);

    // Pick the winner from the current requests and the previous grant.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        any   = i_req | d_req;
        grant = CL_I;
        if (i_req && d_req) begin
            grant = (last_grant == CL_I) ? CL_D : CL_I;
        end else if (d_req) begin
            grant = CL_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one word-addressed memory between the
// read-only instruction cache and the read/write data cache. Requests are
// serialised with round-robin fairness; each access is bounded by a wait
// timeout that forces completion and raises a sticky error flag.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    // instruction cache
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [DATA_WIDTH-1:0] i_readdata,
    output logic                  i_busywait,
    // data cache
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_writedata,
    output logic [DATA_WIDTH-1:0] d_readdata,
    output logic                  d_busywait,
    // memory
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_busywait,
    // status
    output logic                  timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // Value of the wait counter during the last WAIT cycle allowed to stall;
    // a still-busy memory at that edge ends the access by timeout.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t                  state;
    state_t                  state_next;
    client_t                 grant_q;
    client_t                 last_grant;
    client_t                 sel_grant;
    logic                    sel_any;
    op_t                     op_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [CW-1:0]           wait_cnt;
    logic                    i_req;
    logic                    d_req;
    logic                    wait_ok;
    logic                    wait_expire;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // Memory answered at this edge, or gave up after the full wait budget.
    assign wait_ok     = (state == WAIT) && !mem_busywait;
    assign wait_expire = (state == WAIT) && mem_busywait && (wait_cnt == CNT_LAST);

    rr_select2 u_select (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .grant      (sel_grant),
        .any        (sel_any)
    );

    // The latched request drives the memory bus for the whole access.
    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, so it lives inside the
        // clocked block and wins over every other transition.
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: state updates use <= so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sel_any) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (wait_ok || wait_expire) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: strobes during ISSUE/WAIT, winner released during DONE.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        if (state == ISSUE || state == WAIT) begin
            mem_read  = (op_q == OP_RD);
            mem_write = (op_q == OP_WR);
        end
        i_busywait = i_req && !(state == DONE && grant_q == CL_I);
        d_busywait = d_req && !(state == DONE && grant_q == CL_D);
    end

    // Capture the winner's request when leaving IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= CL_I;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && sel_any) begin
            grant_q <= sel_grant;
            if (sel_grant == CL_D) begin
                // A write wins over a read if the D-cache raises both.
                op_q    <= d_write ? OP_WR : OP_RD;
                addr_q  <= d_address;
                wdata_q <= d_writedata;
            end else begin
                op_q    <= OP_RD;
                addr_q  <= i_address;
                wdata_q <= '0;
            end
        end
    end

    // Wait counter: cleared on issue, counts busy WAIT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT && mem_busywait && !wait_expire) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // Read-data registers; each holds until its client's next completed read.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_readdata <= '0;
            d_readdata <= '0;
        end else if (op_q == OP_RD && (wait_ok || wait_expire)) begin
            if (grant_q == CL_I) begin
                i_readdata <= wait_ok ? mem_readdata : '0;
            end else begin
                d_readdata <= wait_ok ? mem_readdata : '0;
            end
        end
    end

    // Sticky timeout flag and round-robin history.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
            last_grant  <= CL_D;
        end else begin
            if (wait_expire) begin
                timeout_err <= 1'b1;
            end
            if (state == DONE) begin
                last_grant <= grant_q;
            end
        end
    end

endmodule
